// File: rtl/potato1_pkg.sv
// Shared definitions for the potato1 datapath: command bit positions,
// instruction opcodes, FSM state type and a small decode helper.
package potato1_pkg;

  localparam int CMD_PC_INC = 0;
  localparam int CMD_PC_DEC = 1;
  localparam int CMD_X_INC  = 2;
  localparam int CMD_X_DEC  = 3;
  localparam int CMD_A_INC  = 4;
  localparam int CMD_A_DEC  = 5;
  localparam int CMD_PUT    = 6;
  localparam int CMD_GET    = 7;

  localparam logic [3:0] OP_PC_INC     = 4'h0;
  localparam logic [3:0] OP_PC_DEC     = 4'h1;
  localparam logic [3:0] OP_X_INC      = 4'h2;
  localparam logic [3:0] OP_X_DEC      = 4'h3;
  localparam logic [3:0] OP_A_INC      = 4'h4;
  localparam logic [3:0] OP_A_DEC      = 4'h5;
  localparam logic [3:0] OP_PUT        = 4'h6;
  localparam logic [3:0] OP_GET        = 4'h7;
  localparam logic [3:0] OP_LOOP_BEGIN = 4'h8;
  localparam logic [3:0] OP_LOOP_END   = 4'h9;
  localparam logic [3:0] OP_HALT       = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_PUT_WAIT = 2'b01,
    ST_GET_WAIT = 2'b10
  } state_t;

  // An INC/DEC pair cancels out, so a step happens only when one side is alone.
  function automatic logic step_only(input logic this_dir, input logic other_dir);
    return this_dir & ~other_dir;
  endfunction

endpackage

// File: rtl/potato1_data_ram.sv
// Data cell array of the potato1 datapath: read/modify/write of the cell at
// the current data pointer plus the zero flag for that cell.
import potato1_pkg::*;

module potato1_data_ram #(
  parameter int X_WIDTH    = 4,
  parameter int CELL_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [X_WIDTH-1:0]    addr,
  input  logic                  inc,
  input  logic                  dec,
  input  logic                  wr_en,
  input  logic [CELL_WIDTH-1:0] wr_data,
  output logic [CELL_WIDTH-1:0] rd_data,
  output logic                  zero
);

  logic [CELL_WIDTH-1:0] cells [2**X_WIDTH];

  // Cells are cleared on reset; an input write never coincides with arithmetic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**X_WIDTH; i++) cells[i] <= '0;
    end else if (wr_en) begin
      cells[addr] <= wr_data;
    end else if (step_only(inc, dec)) begin
      cells[addr] <= cells[addr] + 1'b1;
    end else if (step_only(dec, inc)) begin
      cells[addr] <= cells[addr] - 1'b1;
    end
  end

  assign rd_data = cells[addr];
  assign zero    = (rd_data == '0);

endmodule

// File: rtl/potato1_datapath.sv
// potato1 datapath: PC, data pointer, data cells, program memory and I/O
// handshake FSM. Define POTATO1_STEP_COUNT_EN to enable the Step_Count counter.
import potato1_pkg::*;

module potato1_datapath #(
  parameter int PC_WIDTH   = 8,
  parameter int X_WIDTH    = 4,
  parameter int CELL_WIDTH = 8
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic [7:0]            Command,
  output logic [3:0]            Instruction,
  output logic                  State,
  output logic                  IOReady,
  input  logic                  Prog_We,
  input  logic [PC_WIDTH-1:0]   Prog_Addr,
  input  logic [3:0]            Prog_Data,
  output logic [CELL_WIDTH-1:0] Out_Data,
  output logic                  Out_Valid,
  input  logic                  Out_Ready,
  input  logic [CELL_WIDTH-1:0] In_Data,
  input  logic                  In_Valid,
  output logic                  In_Ready,
  output logic [15:0]           Step_Count
);

  state_t                state;
  logic [PC_WIDTH-1:0]   pc;
  logic [X_WIDTH-1:0]    x;
  logic [CELL_WIDTH-1:0] cell_rd;
  logic                  cell_zero;
  logic                  idle;
  logic                  get_done;
  logic [3:0]            prog_mem [2**PC_WIDTH];

  assign idle     = (state == ST_IDLE);
  assign get_done = (state == ST_GET_WAIT) && In_Valid && In_Ready;

  potato1_data_ram #(
    .X_WIDTH    (X_WIDTH),
    .CELL_WIDTH (CELL_WIDTH)
  ) u_data_ram (
    .clk     (Clock),
    .rst_n   (Reset_n),
    .addr    (x),
    .inc     (idle && Command[CMD_A_INC]),
    .dec     (idle && Command[CMD_A_DEC]),
    .wr_en   (get_done),
    .wr_data (In_Data),
    .rd_data (cell_rd),
    .zero    (cell_zero)
  );

  // Program memory is loaded externally and deliberately survives reset.
  always_ff @(posedge Clock) begin
    if (Prog_We) prog_mem[Prog_Addr] <= Prog_Data;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      pc <= '0;
      x  <= '0;
    end else if (idle) begin
      if (step_only(Command[CMD_PC_INC], Command[CMD_PC_DEC]))      pc <= pc + 1'b1;
      else if (step_only(Command[CMD_PC_DEC], Command[CMD_PC_INC])) pc <= pc - 1'b1;
      if (step_only(Command[CMD_X_INC], Command[CMD_X_DEC]))        x <= x + 1'b1;
      else if (step_only(Command[CMD_X_DEC], Command[CMD_X_INC]))   x <= x - 1'b1;
    end
  end

  // PUT wins over GET when both are requested in the same command.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ST_IDLE;
      Out_Data  <= '0;
      Out_Valid <= 1'b0;
      In_Ready  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Command[CMD_PUT]) begin
            Out_Data  <= cell_rd;
            Out_Valid <= 1'b1;
            state     <= ST_PUT_WAIT;
          end else if (Command[CMD_GET]) begin
            In_Ready <= 1'b1;
            state    <= ST_GET_WAIT;
          end
        end
        ST_PUT_WAIT: begin
          if (Out_Valid && Out_Ready) begin
            Out_Valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_GET_WAIT: begin
          if (In_Valid && In_Ready) begin
            In_Ready <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: begin
          Out_Valid <= 1'b0;
          In_Ready  <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign Instruction = prog_mem[pc];
  assign State       = cell_zero;
  assign IOReady     = idle;

`ifdef POTATO1_STEP_COUNT_EN
  logic [15:0] step_count;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      step_count <= '0;
    end else if (idle && (Command != 8'h00) && (step_count != 16'hFFFF)) begin
      step_count <= step_count + 1'b1;
    end
  end

  assign Step_Count = step_count;
`else
  assign Step_Count = 16'h0000;
`endif

endmodule

// File: tb/tb_potato1_datapath.sv
// Self-checking bench for potato1_datapath: a behavioural model predicts
// cell/pointer state and a queue scoreboard checks every PUT result.
module tb_potato1_datapath;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic [7:0]  Command;
  logic [3:0]  Instruction;
  logic        State;
  logic        IOReady;
  logic        Prog_We;
  logic [7:0]  Prog_Addr;
  logic [3:0]  Prog_Data;
  logic [7:0]  Out_Data;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [7:0]  In_Data;
  logic        In_Valid;
  logic        In_Ready;
  logic [15:0] Step_Count;

`ifdef POTATO1_STEP_COUNT_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  int         compared   = 0;
  int         mismatched = 0;
  logic [7:0] exp_out [$];

  logic [7:0] m_cell [16];
  logic [3:0] m_x;
  logic [7:0] m_pc;
  logic       m_busy;
  int         m_steps;

  potato1_datapath dut (
    .Clock       (Clock),
    .Reset_n     (Reset_n),
    .Command     (Command),
    .Instruction (Instruction),
    .State       (State),
    .IOReady     (IOReady),
    .Prog_We     (Prog_We),
    .Prog_Addr   (Prog_Addr),
    .Prog_Data   (Prog_Data),
    .Out_Data    (Out_Data),
    .Out_Valid   (Out_Valid),
    .Out_Ready   (Out_Ready),
    .In_Data     (In_Data),
    .In_Valid    (In_Valid),
    .In_Ready    (In_Ready),
    .Step_Count  (Step_Count)
  );

  always #5 Clock = ~Clock;

  function automatic logic [3:0] prog_word(input logic [7:0] a);
    return 4'(a[3:0] + a[7:4] * 4'd3 + 4'd1);
  endfunction

  function automatic logic [15:0] exp_zero();
    return {15'h0, (m_cell[m_x] == 8'h00)};
  endfunction

  task automatic resetModel();
    for (int i = 0; i < 16; i++) m_cell[i] = 8'h00;
    m_x     = 4'h0;
    m_pc    = 8'h00;
    m_busy  = 1'b0;
    m_steps = 0;
    exp_out.delete();
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one command for one cycle from a falling edge; returns at the next falling edge.
  task automatic applyStimulus(input logic [7:0] cmd);
    if (!m_busy) begin
      if (cmd != 8'h00 && m_steps < 65535) m_steps++;
      if (cmd[6]) begin
        exp_out.push_back(m_cell[m_x]);
        m_busy = 1'b1;
      end else if (cmd[7]) begin
        m_busy = 1'b1;
      end
      if (cmd[4] && !cmd[5]) m_cell[m_x] = m_cell[m_x] + 8'd1;
      if (cmd[5] && !cmd[4]) m_cell[m_x] = m_cell[m_x] - 8'd1;
      if (cmd[0] && !cmd[1]) m_pc = m_pc + 8'd1;
      if (cmd[1] && !cmd[0]) m_pc = m_pc - 8'd1;
      if (cmd[2] && !cmd[3]) m_x = m_x + 4'd1;
      if (cmd[3] && !cmd[2]) m_x = m_x - 4'd1;
    end
    Command = cmd;
    @(negedge Clock);
    Command = 8'h00;
  endtask

  task automatic drainPut(input int stall);
    int waited = 0;
    logic [7:0] exp;
    while (!Out_Valid && waited < 8) begin
      @(negedge Clock);
      waited++;
    end
    checkOutput("put_valid", {15'h0, Out_Valid}, 16'h0001);
    for (int i = 0; i < stall; i++) begin
      checkOutput("put_ioready_busy", {15'h0, IOReady}, 16'h0000);
      checkOutput("put_hold", {8'h00, Out_Data}, {8'h00, (exp_out.size() > 0) ? exp_out[0] : 8'hxx});
      @(negedge Clock);
    end
    Out_Ready = 1'b1;
    exp = (exp_out.size() > 0) ? exp_out.pop_front() : 8'hxx;
    checkOutput("put_data", {8'h00, Out_Data}, {8'h00, exp});
    @(negedge Clock);
    Out_Ready = 1'b0;
    m_busy    = 1'b0;
    checkOutput("put_valid_clear", {15'h0, Out_Valid}, 16'h0000);
    checkOutput("put_ioready_idle", {15'h0, IOReady}, 16'h0001);
  endtask

  task automatic doGet(input int delay, input logic [7:0] data, input logic [7:0] mid_cmd);
    checkOutput("get_in_ready", {15'h0, In_Ready}, 16'h0001);
    checkOutput("get_ioready_busy", {15'h0, IOReady}, 16'h0000);
    repeat (delay) applyStimulus(mid_cmd);
    In_Data  = data;
    In_Valid = 1'b1;
    @(negedge Clock);
    In_Valid     = 1'b0;
    m_cell[m_x]  = data;
    m_busy       = 1'b0;
    checkOutput("get_in_ready_clear", {15'h0, In_Ready}, 16'h0000);
    checkOutput("get_ioready_idle", {15'h0, IOReady}, 16'h0001);
  endtask

  initial begin
    Reset_n   = 1'b0;
    Command   = 8'h00;
    Prog_We   = 1'b0;
    Prog_Addr = 8'h00;
    Prog_Data = 4'h0;
    Out_Ready = 1'b0;
    In_Data   = 8'h00;
    In_Valid  = 1'b0;
    resetModel();

    for (int a = 0; a < 256; a++) begin
      @(negedge Clock);
      Prog_We   = 1'b1;
      Prog_Addr = 8'(a);
      Prog_Data = prog_word(8'(a));
    end
    @(negedge Clock);
    Prog_We = 1'b0;

    checkOutput("rst_ioready", {15'h0, IOReady}, 16'h0001);
    checkOutput("rst_state", {15'h0, State}, 16'h0001);
    checkOutput("rst_out_valid", {15'h0, Out_Valid}, 16'h0000);
    checkOutput("rst_in_ready", {15'h0, In_Ready}, 16'h0000);
    checkOutput("rst_out_data", {8'h00, Out_Data}, 16'h0000);
    checkOutput("rst_step_count", Step_Count, 16'h0000);
    Reset_n = 1'b1;
    @(negedge Clock);
    checkOutput("instr_pc0", {12'h0, Instruction}, {12'h0, prog_word(m_pc)});

    repeat (3) applyStimulus(8'h10);
    checkOutput("state_after_inc3", {15'h0, State}, 16'h0000);
    applyStimulus(8'h40);
    drainPut(0);
    repeat (3) applyStimulus(8'h20);
    checkOutput("state_after_dec3", {15'h0, State}, 16'h0001);

    applyStimulus(8'h08);
    applyStimulus(8'h10);
    checkOutput("state_cell_f", {15'h0, State}, exp_zero());
    applyStimulus(8'h04);
    checkOutput("state_x_wrap", {15'h0, State}, exp_zero());
    applyStimulus(8'h08);
    applyStimulus(8'h40);
    drainPut(0);
    applyStimulus(8'h04);

    applyStimulus(8'h02);
    checkOutput("instr_pc_wrap_down", {12'h0, Instruction}, {12'h0, prog_word(m_pc)});
    applyStimulus(8'h01);
    checkOutput("instr_pc_wrap_up", {12'h0, Instruction}, {12'h0, prog_word(m_pc)});
    applyStimulus(8'h01);
    applyStimulus(8'h03);
    checkOutput("instr_pc_incdec", {12'h0, Instruction}, {12'h0, prog_word(m_pc)});
    applyStimulus(8'h30);
    applyStimulus(8'h0C);
    checkOutput("state_a_incdec", {15'h0, State}, exp_zero());

    repeat (65) applyStimulus(8'h10);
    applyStimulus(8'h40);
    drainPut(3);

    applyStimulus(8'h80);
    doGet(2, 8'h00, 8'h10);
    checkOutput("state_after_get", {15'h0, State}, exp_zero());
    applyStimulus(8'h40);
    drainPut(0);

    applyStimulus(8'h10);
    applyStimulus(8'hC0);
    checkOutput("putget_in_ready", {15'h0, In_Ready}, 16'h0000);
    drainPut(1);

    applyStimulus(8'h80);
    checkOutput("abort_in_ready_set", {15'h0, In_Ready}, 16'h0001);
    In_Data = 8'h55;
    #2 Reset_n = 1'b0;
    #1;
    checkOutput("abort_in_ready", {15'h0, In_Ready}, 16'h0000);
    checkOutput("abort_ioready", {15'h0, IOReady}, 16'h0001);
    checkOutput("abort_state", {15'h0, State}, 16'h0001);
    @(negedge Clock);
    Reset_n = 1'b1;
    resetModel();
    @(negedge Clock);
    checkOutput("post_abort_state", {15'h0, State}, 16'h0001);
    checkOutput("prog_survives_reset", {12'h0, Instruction}, {12'h0, prog_word(8'h00)});

    Prog_We   = 1'b1;
    Prog_Addr = m_pc;
    Prog_Data = 4'h7;
    @(negedge Clock);
    Prog_We = 1'b0;
    checkOutput("prog_write_pc", {12'h0, Instruction}, 16'h0007);

    applyStimulus(8'h10);
    applyStimulus(8'h10);
    applyStimulus(8'h04);
    applyStimulus(8'h20);
    applyStimulus(8'h08);
    checkOutput("step_count", Step_Count, STEP_EN ? 16'(m_steps) : 16'h0000);
    checkOutput("state_final", {15'h0, State}, exp_zero());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
